// File: rtl/serial_adder4_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the controller state encoding and the default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder4_fa_bit.sv
// Single-bit full adder slice used once per cycle by the serial adder.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder4.sv
// Bit-serial adder: one full-adder slice per cycle, LSB first, valid/ready on both sides.
// Optional overflow flag enabled with the SERIAL_ADDER_OVF_EN macro.
module serial_adder4
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(WIDTH);

  state_t           state;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic             accept;

  assign accept = (state == IDLE) && in_valid;

  fa_bit u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Operand shift registers: pure data, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == BUSY && cnt != DONE_CNT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
    end
  end

  // Controller; the extra BUSY cycle at cnt==WIDTH lands out_valid at WIDTH+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      res         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry      <= cin;
            res        <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == DONE_CNT) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            res   <= {fa_s, res[WIDTH-1:1]};
            carry <= fa_co;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (accept) begin
      ovf_r <= 1'b0;
    end else if (state == BUSY && cnt == LAST_BIT) begin
      ovf_r <= carry ^ fa_co;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = {carry, res};

endmodule

// File: tb/tb_serial_adder4.sv
// Bench for serial_adder4: directed corner cases, exhaustive operand sweep and random traffic.
module tb_serial_adder4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         ovf;

  int vectors     = 0;
  int miscompares = 0;

  serial_adder4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic logic ref_ovf(input int ua, input int ub, input int c);
    int sa;
    int sb;
    int s;
`ifdef SERIAL_ADDER_OVF_EN
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    s  = sa + sb + c;
    return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
`else
    sa = ua; sb = ub; s = c;
    return 1'b0;
`endif
  endfunction

  // One full transaction: accept, scrambled inputs while busy, backpressure, handshake
  task automatic do_op(input int ua, input int ub, input int c, input int hold);
    int lat;
    int exp_sum;
    logic exp_ovf;
    exp_sum = ua + ub + c;
    exp_ovf = ref_ovf(ua, ub, c);
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = W'(ua);
    b = W'(ub);
    cin = 1'(c);
    step();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      chk("ready_low_busy", 32'(in_ready), 32'd0);
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      cin = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(W + 1));
    chk("sum", 32'(sum), 32'(exp_sum));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'(exp_sum));
      chk("hold_ovf", 32'(ovf), 32'(exp_ovf));
      chk("hold_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("ready_low_handshake", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_after_done", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    step();

    do_op(0, 0, 0, 0);
    do_op(15, 15, 1, 0);
    do_op(15, 15, 0, 1);
    do_op(9, 7, 0, 3);
    do_op(7, 1, 0, 0);
    do_op(15, 1, 0, 0);
    do_op(8, 8, 0, 2);

    // Abort on the second BUSY cycle
    in_valid = 1'b1;
    a = 4'd5;
    b = 4'd6;
    cin = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    do_op(3, 4, 0, 0);

    for (int x = 0; x < (1 << W); x++)
      for (int y = 0; y < (1 << W); y++)
        for (int c = 0; c < 2; c++)
          do_op(x, y, c, int'($urandom_range(0, 1)));

    for (int n = 0; n < 40; n++)
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 4)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder4.md
SERIAL_ADDER4 -- requirements
Module: serial_adder4

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  operand pair a/b/cin presented.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  unsigned addend A.
REQ-007 Port: b  input  WIDTH  unsigned addend B.
REQ-008 Port: cin  input  1  carry-in of the LSB.
REQ-009 Port: out_valid  output  1  sum is available.
REQ-010 Port: out_ready  input  1  consumer accepts sum.
REQ-011 Port: sum  output  WIDTH+1  result; MSB is the final carry-out.
REQ-012 Port: ovf  output  1  two's-complement overflow flag (see Configuration).

Function
REQ-013 The block SHALL add a + b + cin bit-serially, LSB first, using one full-adder slice per cycle.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, latch a, b, cin into shift registers, clear the bit counter, and go to BUSY.
REQ-016 BUSY: each cycle, add the current LSBs with the carry register, shift the sum bit into the result register from the MSB side, update carry, and increment the counter; after the WIDTH-th bit, go to DONE.
REQ-017 DONE: out_valid=1; sum = {carry, result bits}; on out_valid&out_ready, go to IDLE.
REQ-018 Latency SHALL be exactly WIDTH+1 cycles from the accepting edge to the first cycle out_valid is high (WIDTH=4: 5 cycles).
REQ-019 in_ready SHALL be 0 in BUSY and DONE; in_valid there is ignored and a/b/cin are not sampled.
REQ-020 sum and ovf SHALL hold stable while out_valid=1 and out_ready=0 (backpressure of any length).
REQ-021 sum SHALL be WIDTH+1 bits wide and zero-extended, with no truncation; the all-ones inputs with cin=1 give 2^(WIDTH+1)-1.
REQ-022 No new operand SHALL be accepted in the cycle the DONE handshake completes; in_ready rises the following cycle.
REQ-023 Changes on a/b/cin after acceptance SHALL NOT affect the result in progress.

Reset
REQ-024 While rst=1, the block SHALL be in state IDLE, with in_ready=1, out_valid=0, sum=0, ovf=0, carry=0, and counter=0.
REQ-025 rst asserted mid-BUSY or mid-DONE SHALL abort the operation immediately; no out_valid pulse follows for the aborted operation.

Configuration
REQ-026 Macro SERIAL_ADDER_OVF_EN: when defined, ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB, captured at the last BUSY bit and valid with out_valid.
REQ-027 When SERIAL_ADDER_OVF_EN is not defined, the ovf port SHALL remain and be tied to 0, with no overflow logic synthesized.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the state enumeration (IDLE/BUSY/DONE) and the default width constant DEF_WIDTH=4.
REQ-029 The per-bit adder SHALL be a separate combinational sub-module, fa_bit (inputs x, y, ci; outputs s, co), instantiated once.
REQ-030 The bit counter SHALL be $clog2(WIDTH+1) bits wide; no other arithmetic beyond fa_bit is permitted in the datapath.

Verification
REQ-031 a=0, b=0, cin=0 -> out_valid 5 cycles after accept, sum=5'b00000, ovf=0.
REQ-032 a=15, b=15, cin=1 -> sum=5'b11111 (31); a=15, b=15, cin=0 -> sum=5'b11110 (30).
REQ-033 Exhaustive 256 pairs, each with cin=0 and cin=1, checked against a + b + cin -> every sum matches, with latency fixed at 5.
REQ-034 a=9, b=7 accepted, out_ready held low 3 cycles -> sum=5'b10000 held for 4 cycles, in_ready=0 throughout; after the handshake, IDLE the next cycle.
REQ-035 rst pulsed on the 2nd BUSY cycle -> out_valid stays 0, in_ready=1 after release, and a following 3+4 yields 7.
REQ-036 With SERIAL_ADDER_OVF_EN: a=4'b0111, b=4'b0001 -> ovf=1 and sum=5'b01000; a=4'b1111, b=4'b0001 -> ovf=0. Without the macro, ovf=0 in all cases.
